// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter flop: redirect load wins over sequential increment, else hold.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_value,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + PC_STEP;  // modulo 2^32 wrap is intended
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives instruction memory from the PC and registers the returned
// word with its address into a valid/ready output stage for decode.
//
// state   | meaning
// S_IDLE  | reset state, no fetching; waits for EN
// S_RUN   | fetching one instruction per accepted cycle
// S_DRAIN | EN dropped; waits for the last output to be accepted
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  output logic [XLEN-1:0] ADDR,
  input  logic [XLEN-1:0] INST,
  input  logic            BR_TAKEN,
  input  logic [XLEN-1:0] BR_TARGET,
  output logic            VALID,
  input  logic            READY,
  output logic [XLEN-1:0] INST_OUT,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] FETCH_CNT,
  output logic            ERR_ALIGN
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic            adv;
  logic            xfer;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc;

  assign adv            = (state == S_RUN) && (!VALID || READY);
  assign xfer           = VALID && READY;
  assign target_aligned = {BR_TARGET[XLEN-1:2], 2'b00};
  assign ADDR           = pc;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (BR_TAKEN),
    .load_value (target_aligned),
    .inc        (adv),
    .pc         (pc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (EN) state_nxt = S_RUN;
      S_RUN:   if (!EN) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (EN) begin
          state_nxt = S_RUN;
        end else if (!VALID) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A redirect flushes the output even if the current word is being accepted;
  // that transfer still counts below.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALID    <= 1'b0;
      INST_OUT <= '0;
      PC_OUT   <= '0;
    end else if (BR_TAKEN) begin
      VALID <= 1'b0;
    end else if (adv) begin
      VALID    <= 1'b1;
      INST_OUT <= INST;
      PC_OUT   <= pc;
    end else if (xfer) begin
      VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FETCH_CNT <= '0;
      ERR_ALIGN <= 1'b0;
    end else begin
      if (xfer) begin
        FETCH_CNT <= FETCH_CNT + 32'd1;
      end
      ERR_ALIGN <= BR_TAKEN && (BR_TARGET[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit with a per-cycle expectation queue.
module tb_instruction_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [31:0] ADDR;
  logic [31:0] INST;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        VALID;
  logic        READY;
  logic [31:0] INST_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] FETCH_CNT;
  logic        ERR_ALIGN;

  always #5 CLK = ~CLK;

  // Instruction memory model: word is a function of its address.
  assign INST = ADDR ^ PAT;

  instruction_fetch_unit dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .ADDR      (ADDR),
    .INST      (INST),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .VALID     (VALID),
    .READY     (READY),
    .INST_OUT  (INST_OUT),
    .PC_OUT    (PC_OUT),
    .FETCH_CNT (FETCH_CNT),
    .ERR_ALIGN (ERR_ALIGN)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc_out;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t tv[23];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // en rdy br target | addr valid pc_out cnt err  (expected after the edge)
    tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'd0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'd0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'd1, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'd2, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'd2, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'd2, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'd2, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h10,        1'b1, 32'hC,         32'd3, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h14,        1'b1, 32'h10,        32'd4, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 32'h40,        32'h40,        1'b0, 32'h10,        32'd5, 1'b0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h44,        1'b1, 32'h40,        32'd5, 1'b0};
    tv[11] = '{1'b1, 1'b0, 1'b1, 32'h42,        32'h40,        1'b0, 32'h40,        32'd5, 1'b1};
    tv[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h44,        1'b1, 32'h40,        32'd5, 1'b0};
    tv[13] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h40,        32'd6, 1'b0};
    tv[14] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC, 32'd6, 1'b0};
    tv[15] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'd7, 1'b0};
    tv[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'd7, 1'b0};
    tv[17] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4,         1'b0, 32'h0,         32'd8, 1'b0};
    tv[18] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4,         1'b0, 32'h0,         32'd8, 1'b0};
    tv[19] = '{1'b0, 1'b1, 1'b1, 32'h100,       32'h100,       1'b0, 32'h0,         32'd8, 1'b0};
    tv[20] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h100,       1'b0, 32'h0,         32'd8, 1'b0};
    tv[21] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h104,       1'b1, 32'h100,       32'd8, 1'b0};
    tv[22] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h104,       1'b1, 32'h100,       32'd8, 1'b0};

    RST_N     = 1'b0;
    EN        = 1'b0;
    READY     = 1'b0;
    BR_TAKEN  = 1'b0;
    BR_TARGET = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst addr",     ADDR,             32'h0);
    chk("rst valid",    {31'd0, VALID},   32'd0);
    chk("rst inst_out", INST_OUT,         32'h0);
    chk("rst pc_out",   PC_OUT,           32'h0);
    chk("rst cnt",      FETCH_CNT,        32'd0);
    chk("rst err",      {31'd0, ERR_ALIGN}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 23; i++) begin
      vec_t e;
      EN        = tv[i].en;
      READY     = tv[i].rdy;
      BR_TAKEN  = tv[i].br;
      BR_TARGET = tv[i].tgt;
      sb.push_back(tv[i]);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d addr", i),   ADDR,               e.addr);
      chk($sformatf("v%0d valid", i),  {31'd0, VALID},     {31'd0, e.valid});
      chk($sformatf("v%0d pc_out", i), PC_OUT,             e.pc_out);
      chk($sformatf("v%0d cnt", i),    FETCH_CNT,          e.cnt);
      chk($sformatf("v%0d err", i),    {31'd0, ERR_ALIGN}, {31'd0, e.err});
      if (e.valid) begin
        chk($sformatf("v%0d inst_out", i), INST_OUT, e.pc_out ^ PAT);
      end
    end
    BR_TAKEN = 1'b0;

    // Asynchronous reset between edges while stalled with a live output.
    #2;
    RST_N = 1'b0;
    #1;
    chk("async addr",   ADDR,               32'h0);
    chk("async valid",  {31'd0, VALID},     32'd0);
    chk("async cnt",    FETCH_CNT,          32'd0);
    chk("async err",    {31'd0, ERR_ALIGN}, 32'd0);
    chk("async pc_out", PC_OUT,             32'h0);
    @(negedge CLK);
    EN    = 1'b0;
    READY = 1'b1;
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("idle%0d addr", k),  ADDR,           32'h0);
      chk($sformatf("idle%0d valid", k), {31'd0, VALID}, 32'd0);
    end

    // Leaving idle: EN at cycle N -> RUN at N+1 -> first valid at N+2.
    EN = 1'b1;
    @(posedge CLK);
    #1;
    chk("en n+1 valid", {31'd0, VALID}, 32'd0);
    @(posedge CLK);
    #1;
    chk("en n+2 valid",  {31'd0, VALID}, 32'd1);
    chk("en n+2 pc_out", PC_OUT,         32'h0);
    chk("en n+2 addr",   ADDR,           32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage that drives the instruction memory and hands instructions to decode. It owns the program counter (PC), presents the PC combinationally on `ADDR`, samples the returned `INST` the same cycle, and registers it with its PC into a valid/ready output stage. It handles taken-branch redirects with a one-cycle flush and back-pressure from decode.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `PC_STEP`, 4: byte increment between sequential fetches.
- `CLK` input 1: rising-edge clock.
- `RST_N` input 1: asynchronous, active-low reset.
- `EN` input 1: fetch enable; 0 stops new fetches.
- `ADDR` output 32: instruction memory address, equal to the PC register.
- `INST` input 32: instruction word from memory, valid in the same cycle as `ADDR`.
- `BR_TAKEN` input 1: redirect request, single-cycle pulse.
- `BR_TARGET` input 32: redirect byte address.
- `VALID` output 1: `INST_OUT` and `PC_OUT` hold a live instruction.
- `READY` input 1: decode accepts the output this cycle.
- `INST_OUT` output 32: registered instruction.
- `PC_OUT` output 32: address `INST_OUT` was fetched from.
- `FETCH_CNT` output 32: number of completed transfers (`VALID && READY`).
- `ERR_ALIGN` output 1: one-cycle pulse when a misaligned target is taken.

## Operation
- FSM states:
  - `S_IDLE`: reset state. Goes to `S_RUN` when `EN=1`.
  - `S_RUN`: fetching. Goes to `S_DRAIN` when `EN=0`.
  - `S_DRAIN`: no new fetches. Goes to `S_IDLE` once `VALID=0`, or to `S_RUN` if `EN=1` again.
- Advance condition `adv = (state==S_RUN) && (!VALID || READY)`.
  - On `adv`: `INST_OUT<=INST`, `PC_OUT<=PC`, `VALID<=1`, `PC<=PC+PC_STEP`.
- Hold: when `VALID && !READY`, the PC, `INST_OUT`, `PC_OUT` and `VALID` stay unchanged. `ADDR` stays stable.
- Drain / idle: `VALID` clears on the cycle after acceptance when no new fetch is made.
- Redirect: `BR_TAKEN=1` has priority over every other PC update.
  - `PC<={BR_TARGET[31:2],2'b00}`.
  - `VALID<=0` next cycle (flush), regardless of `READY`.
  - Redirects are honoured in every state, including `S_IDLE`.
- Redirect coinciding with a transfer: if `VALID && READY && BR_TAKEN` in the same cycle, the transfer completes and is counted, then the output is flushed.
- `ERR_ALIGN` pulses for one cycle when `BR_TAKEN && BR_TARGET[1:0]!=0`.
- Arithmetic:
  - PC addition is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to `0`.
  - `FETCH_CNT` wraps from `32'hFFFF_FFFF` to `0`.
- Reset values: `PC=RESET_PC` (so `ADDR=RESET_PC`), `VALID=0`, `INST_OUT=0`, `PC_OUT=0`, `FETCH_CNT=0`, `ERR_ALIGN=0`, state `S_IDLE`.
- Reset asserted mid-operation returns every register to its reset value immediately. Any instruction in flight is discarded and not counted.

## Timing
- `ADDR` changes only on a `CLK` edge or on reset, never combinationally from inputs.
- Fetch latency: an instruction at `ADDR` in cycle N appears on `INST_OUT` with `VALID=1` in cycle N+1.
- Throughput: one instruction per cycle while `READY=1` and `EN=1`.
- Branch penalty:
  - `BR_TAKEN` in cycle N gives `ADDR=target` and `VALID=0` in N+1.
  - The target instruction is valid in N+2.
- After a back-pressure release (`READY` 0→1 in cycle N), the next instruction appears in N+1. No bubble.
- `EN` 0→1 in `S_IDLE` at cycle N: state is `S_RUN` in N+1, first valid output in N+2.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum `fetch_state_t` (`S_IDLE`, `S_RUN`, `S_DRAIN`);
  - `RESET_PC_DEF` and `PC_STEP_DEF` constants;
  - `XLEN=32`.
- One sub-module, `pc_register`: the PC flop with async active-low reset, load (redirect), increment and hold controls.
- The output stage, FSM and counter stay in the top module.

## Test plan
- Reset then `EN=1`, `READY=1`, memory returning `INST=ADDR^32'hA5A5_0000`:
  - `ADDR` sequence 0, 4, 8, 12;
  - `PC_OUT` lags `ADDR` by one cycle;
  - `FETCH_CNT=4` after 4 transfers.
- `READY=0` for 3 cycles while `VALID=1` at `PC_OUT=8`:
  - `ADDR` holds at 12, `INST_OUT` unchanged, `FETCH_CNT` unchanged;
  - on release, `PC_OUT=12` the next cycle.
- `BR_TAKEN` with `BR_TARGET=32'h40` in cycle N:
  - N+1: `ADDR=32'h40`, `VALID=0`;
  - N+2: `PC_OUT=32'h40`, `VALID=1`.
- `BR_TARGET=32'h42`: `ADDR=32'h40` next cycle and `ERR_ALIGN` high for exactly one cycle. Separately, `BR_TAKEN` with `VALID && READY` in the same cycle: `FETCH_CNT` increments, then `VALID=0`.
- Redirect to `32'hFFFF_FFFC`, `READY=1`: the next `ADDR` is `0` (wrap-around).
- `RST_N` pulled low asynchronously between edges during a stall: `VALID`, `FETCH_CNT` and `ERR_ALIGN` go to 0 and `ADDR` goes to `RESET_PC` immediately. After release with `EN=0`, the block stays in `S_IDLE` with `ADDR` stable.
